// File: rtl/swcap_bank_ctrl_pkg.sv
// Shared types and helpers for the switched-capacitor bank sequencer.
// Holds the FSM state encoding, the code-width helper and the thermometer bit function.
package swcap_ctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_STEP   = 2'd1;
   localparam state_t ST_SETTLE = 2'd2;
   localparam state_t ST_DONE   = 2'd3;

   function automatic int codeWidth(input int nCaps);
      return $clog2(nCaps + 1);
   endfunction

   // Bit idx of the thermometer image of a binary cap count.
   function automatic logic therm_from_bin(input int code, input int idx);
      return code > idx;
   endfunction

endpackage

// File: rtl/swcap_bank_ctrl_if.sv
// Target handshake and bank status bundle between the frequency loop and the sequencer.
interface swcap_bank_ctrl_if
   import swcap_ctrl_pkg::*;
#(
   parameter int N_CAPS = 32,
   parameter int CW     = codeWidth(N_CAPS)
);

   logic [CW-1:0]     tgt_code;
   logic              tgt_valid;
   logic              tgt_ready;
   logic              hold;
   logic [N_CAPS-1:0] sw;
   logic [CW-1:0]     cur_code;
   logic              busy;
   logic              done;
   logic              sat;

   modport master (
      output tgt_code, tgt_valid, hold,
      input  tgt_ready, sw, cur_code, busy, done, sat
   );

   modport slave (
      input  tgt_code, tgt_valid, hold,
      output tgt_ready, sw, cur_code, busy, done, sat
   );

endinterface

// File: rtl/swcap_bank_ctrl_therm_enc.sv
// Combinational binary-to-thermometer encoder feeding the registered cap gate drive.
module swcap_therm_enc
   import swcap_ctrl_pkg::*;
#(
   parameter int N_CAPS = 32,
   parameter int CW     = codeWidth(N_CAPS)
) (
   input  logic [CW-1:0]     code,
   output logic [N_CAPS-1:0] therm
);

   for (genvar i = 0; i < N_CAPS; i++) begin : gBit
      assign therm[i] = therm_from_bin(int'(code), i);
   end

endmodule

// File: rtl/swcap_bank_ctrl.sv
// Walks the switched-cap bank one cell at a time toward an accepted target code,
// pausing a programmable settling interval after every switch.
module swcap_bank_ctrl
   import swcap_ctrl_pkg::*;
#(
   parameter int N_CAPS     = 32,
   parameter int SETTLE_CYC = 8,
   parameter int CW         = codeWidth(N_CAPS)
) (
   input logic             clk,
   input logic             reset,
   swcap_bank_ctrl_if.slave bus
);

   localparam int                CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0]     MAX_CODE = CW'(N_CAPS);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

   state_t            state;
   logic [CNT_W-1:0]  settleCnt;
   logic [CW-1:0]     curCode;
   logic [CW-1:0]     tgtReg;
   logic [CW-1:0]     nextCode;
   logic [CW-1:0]     tgtClamp;
   logic [N_CAPS-1:0] swReg;
   logic [N_CAPS-1:0] swNext;
   logic              tgtReadyReg;
   logic              busyReg;
   logic              doneReg;
   logic              satReg;
   logic              overRange;
   logic              accept;
   logic              stepping;

   assign overRange = bus.tgt_code > MAX_CODE;
   assign tgtClamp  = overRange ? MAX_CODE : bus.tgt_code;
   assign accept    = (state == ST_IDLE) && tgtReadyReg && bus.tgt_valid;
   assign stepping  = (state == ST_STEP) && !bus.hold;

   // Direction comes from the target compare, so the walk can never overshoot 0 or N_CAPS.
   always_comb begin
      nextCode = curCode;
      if (stepping) begin
         nextCode = (tgtReg > curCode) ? curCode + CW'(1) : curCode - CW'(1);
      end
   end

   swcap_therm_enc #(
      .N_CAPS (N_CAPS),
      .CW     (CW)
   ) uThermEnc (
      .code  (nextCode),
      .therm (swNext)
   );

   // Sequencer FSM plus registered outputs; ready only re-opens one cycle after the done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         settleCnt   <= '0;
         curCode     <= '0;
         tgtReg      <= '0;
         swReg       <= '0;
         tgtReadyReg <= 1'b1;
         busyReg     <= 1'b0;
         doneReg     <= 1'b0;
         satReg      <= 1'b0;
      end else begin
         curCode <= nextCode;
         swReg   <= swNext;
         doneReg <= (state == ST_DONE);
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  tgtReg      <= tgtClamp;
                  satReg      <= overRange;
                  tgtReadyReg <= 1'b0;
                  busyReg     <= 1'b1;
                  state       <= (tgtClamp == curCode) ? ST_DONE : ST_STEP;
               end else begin
                  tgtReadyReg <= 1'b1;
                  busyReg     <= 1'b0;
               end
            end
            ST_STEP: begin
               if (!bus.hold) begin
                  settleCnt <= CNT_LOAD;
                  state     <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (!bus.hold) begin
                  if (settleCnt == '0) begin
                     state <= (curCode == tgtReg) ? ST_DONE : ST_STEP;
                  end else begin
                     settleCnt <= settleCnt - CNT_W'(1);
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.tgt_ready = tgtReadyReg;
   assign bus.sw        = swReg;
   assign bus.cur_code  = curCode;
   assign bus.busy      = busyReg;
   assign bus.done      = doneReg;
   assign bus.sat       = satReg;

endmodule

// File: tb/tb_swcap_bank_ctrl.sv
// Directed plus randomized bench for the cap bank sequencer, checked against a
// timing-formula model of each walk.
module tb_swcap_bank_ctrl;

   localparam int N  = 32;
   localparam int S  = 8;
   localparam int CW = 6;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   modelCode;

   swcap_bank_ctrl_if #(.N_CAPS(N)) bus ();

   swcap_bank_ctrl #(
      .N_CAPS     (N),
      .SETTLE_CYC (S)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] thermOf(input int n);
      logic [63:0] t;
      t = (64'd1 << n) - 64'd1;
      return t;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for ready, then presents one target for a single acceptance edge.
   task automatic applyStimulus(input int code);
      int waited;
      waited = 0;
      while (bus.tgt_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("ready_before_req", 64'(bus.tgt_ready), 64'd1);
      bus.tgt_code  = CW'(code);
      bus.tgt_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.tgt_valid = 1'b0;
   endtask

   // One full walk: every cycle from acceptance until ready returns is compared to the model.
   task automatic runWalk(input int code, input int holdAt, input int holdLen, input bit noise);
      int tgt, d, dir, doneK, last, held, ke, steps, expCur;
      bit expSat, expBusy;
      tgt    = (code > N) ? N : code;
      expSat = (code > N);
      d      = (tgt > modelCode) ? tgt - modelCode : modelCode - tgt;
      dir    = (tgt > modelCode) ? 1 : -1;
      doneK  = d * (S + 1) + 1;
      last   = doneK + holdLen + 1;
      applyStimulus(code);
      for (int k = 0; k <= last; k++) begin
         @(negedge clk);
         held = 0;
         if (holdAt >= 0 && k > holdAt) held = (k - holdAt > holdLen) ? holdLen : k - holdAt;
         ke      = k - held;
         steps   = (ke >= 1 && d > 0) ? (((ke - 1) / (S + 1) + 1 > d) ? d : (ke - 1) / (S + 1) + 1) : 0;
         expCur  = modelCode + dir * steps;
         expBusy = (ke <= doneK);
         checkOutput($sformatf("cur_code t%0d k%0d", code, k), 64'(bus.cur_code), 64'(expCur));
         checkOutput($sformatf("sw t%0d k%0d", code, k), 64'(bus.sw), thermOf(expCur));
         checkOutput($sformatf("done t%0d k%0d", code, k), 64'(bus.done), 64'(ke == doneK));
         checkOutput($sformatf("busy t%0d k%0d", code, k), 64'(bus.busy), 64'(expBusy));
         checkOutput($sformatf("ready t%0d k%0d", code, k), 64'(bus.tgt_ready), 64'(!expBusy));
         checkOutput($sformatf("sat t%0d k%0d", code, k), 64'(bus.sat), 64'(expSat));
         if (k == holdAt) bus.hold = 1'b1;
         if (k == holdAt + holdLen) bus.hold = 1'b0;
         if (noise && k < last - 1) begin
            bus.tgt_valid = 1'($urandom_range(0, 1));
            bus.tgt_code  = CW'($urandom_range(0, 40));
         end
      end
      bus.tgt_valid = 1'b0;
      bus.hold      = 1'b0;
      modelCode     = tgt;
   endtask

   initial begin
      int waited, code, d, holdAt, holdLen;
      total         = 0;
      bad           = 0;
      modelCode     = 0;
      reset         = 1'b1;
      bus.tgt_code  = '0;
      bus.tgt_valid = 1'b0;
      bus.hold      = 1'b0;

      #12;
      checkOutput("rst_sw", 64'(bus.sw), 64'd0);
      checkOutput("rst_cur", 64'(bus.cur_code), 64'd0);
      checkOutput("rst_ready", 64'(bus.tgt_ready), 64'd1);
      checkOutput("rst_busy", 64'(bus.busy), 64'd0);
      checkOutput("rst_done", 64'(bus.done), 64'd0);
      checkOutput("rst_sat", 64'(bus.sat), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] reset asserted mid-walk");
      applyStimulus(10);
      waited = 0;
      while (bus.cur_code !== CW'(3) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("midwalk_reach3", 64'(bus.cur_code), 64'd3);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_rst_sw", 64'(bus.sw), 64'd0);
      checkOutput("async_rst_cur", 64'(bus.cur_code), 64'd0);
      checkOutput("async_rst_ready", 64'(bus.tgt_ready), 64'd1);
      checkOutput("async_rst_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      reset     = 1'b0;
      modelCode = 0;

      $display("[TB] directed walks");
      runWalk(5, -1, 0, 1'b0);
      runWalk(2, -1, 0, 1'b1);
      runWalk(40, -1, 0, 1'b0);
      runWalk(32, -1, 0, 1'b0);
      runWalk(27, 3, 5, 1'b0);
      runWalk(27, -1, 0, 1'b0);

      $display("[TB] randomized walks");
      for (int i = 0; i < 10; i++) begin
         code    = int'($urandom_range(0, 40));
         d       = ((code > N) ? N : code) - modelCode;
         d       = (d < 0) ? -d : d;
         holdAt  = -1;
         holdLen = 0;
         if (d > 0 && $urandom_range(0, 1) == 1) begin
            holdAt  = int'($urandom_range(1, d * (S + 1) - 1));
            holdLen = int'($urandom_range(1, 6));
         end
         runWalk(code, holdAt, holdLen, 1'($urandom_range(0, 1)));
      end
      runWalk(0, -1, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
